// File: rtl/lif_sched.sv
// Time-multiplexed leaky integrate-and-fire scheduler: one shared update datapath swept across all neurons.
// Optional per-neuron refractory counters are compiled in with LIF_SCHED_REFRACTORY_EN.
module lif_sched #(
    parameter int N_NEURONS     = 4,
    parameter int IDX_W         = 2,
    parameter int THRESH_INIT   = 32,
    parameter int REFRAC_SWEEPS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IDX_W-1:0]     in_idx,
    input  logic [7:0]           in_current,
    input  logic                 thr_we,
    input  logic [7:0]           thr_data,
    output logic [N_NEURONS-1:0] spikes,
    output logic                 spike_valid,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic [7:0]           rd_state
);

    typedef enum logic [1:0] {IDLE, UPDATE, DONE} fsm_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    fsm_e                 fsm_q, fsm_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [7:0]           state_q [N_NEURONS];
    logic [7:0]           state_d [N_NEURONS];
    logic [7:0]           acc_q   [N_NEURONS];
    logic [7:0]           acc_d   [N_NEURONS];
    logic [7:0]           thr_q, thr_d;
    logic [N_NEURONS-1:0] shadow_q, shadow_d;
    logic [N_NEURONS-1:0] spikes_q, spikes_d;

    logic [8:0] sum_wide;
    logic [7:0] sum;
    logic       raw_fire;
    logic       fire;
    logic       in_refr;
    logic [8:0] inj_wide;
    logic [7:0] inj_sat;

    // Leak is a right shift of the membrane; the 9-bit sum saturates before the compare.
    assign sum_wide = {1'b0, acc_q[ptr_q]} + {2'b00, state_q[ptr_q][7:1]};
    assign sum      = sum_wide[8] ? 8'hFF : sum_wide[7:0];
    assign raw_fire = (sum >= thr_q);

    assign inj_wide = {1'b0, acc_q[in_idx]} + {1'b0, in_current};
    assign inj_sat  = inj_wide[8] ? 8'hFF : inj_wide[7:0];

`ifdef LIF_SCHED_REFRACTORY_EN
    logic [1:0] refr_q [N_NEURONS];
    logic [1:0] refr_d [N_NEURONS];
    assign in_refr = (refr_q[ptr_q] != 2'd0);
`else
    assign in_refr = 1'b0;
`endif

    assign fire = raw_fire && !in_refr;

    always_comb begin
        fsm_d    = fsm_q;
        ptr_d    = ptr_q;
        state_d  = state_q;
        acc_d    = acc_q;
        thr_d    = thr_q;
        shadow_d = shadow_q;
        spikes_d = spikes_q;
`ifdef LIF_SCHED_REFRACTORY_EN
        refr_d   = refr_q;
`endif
        case (fsm_q)
            IDLE: begin
                if (thr_we) begin
                    thr_d = thr_data;
                end
                if (tick) begin
                    fsm_d    = UPDATE;
                    ptr_d    = '0;
                    shadow_d = '0;
                end
            end
            UPDATE: begin
                state_d[ptr_q]  = (fire || in_refr) ? 8'd0 : sum;
                acc_d[ptr_q]    = 8'd0;
                shadow_d[ptr_q] = fire;
`ifdef LIF_SCHED_REFRACTORY_EN
                if (in_refr) begin
                    refr_d[ptr_q] = refr_q[ptr_q] - 2'd1;
                end else if (fire) begin
                    refr_d[ptr_q] = 2'(REFRAC_SWEEPS);
                end
`endif
                // Spikes load on the edge into DONE so they are visible alongside spike_valid.
                if (ptr_q == LAST_IDX) begin
                    fsm_d    = DONE;
                    spikes_d = shadow_d;
                end else begin
                    ptr_d = ptr_q + IDX_W'(1);
                end
            end
            DONE: begin
                fsm_d = IDLE;
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
        // Injections are blocked during UPDATE, so they never collide with the sweep's acc clear.
        if (in_valid && in_ready) begin
            acc_d[in_idx] = inj_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q    <= IDLE;
            ptr_q    <= '0;
            thr_q    <= 8'(THRESH_INIT);
            shadow_q <= '0;
            spikes_q <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                state_q[i] <= 8'd0;
                acc_q[i]   <= 8'd0;
`ifdef LIF_SCHED_REFRACTORY_EN
                refr_q[i]  <= 2'd0;
`endif
            end
        end else begin
            fsm_q    <= fsm_d;
            ptr_q    <= ptr_d;
            thr_q    <= thr_d;
            shadow_q <= shadow_d;
            spikes_q <= spikes_d;
            for (int i = 0; i < N_NEURONS; i++) begin
                state_q[i] <= state_d[i];
                acc_q[i]   <= acc_d[i];
`ifdef LIF_SCHED_REFRACTORY_EN
                refr_q[i]  <= refr_d[i];
`endif
            end
        end
    end

    assign busy        = (fsm_q != IDLE);
    assign in_ready    = (fsm_q != UPDATE);
    assign spike_valid = (fsm_q == DONE);
    assign spikes      = spikes_q;
    assign rd_state    = state_q[rd_idx];

endmodule

// File: tb/tb_lif_sched.sv
// Directed self-checking bench for lif_sched (default build, 4 neurons, threshold 32).
module tb_lif_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       busy;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_idx;
    logic [7:0] in_current;
    logic       thr_we;
    logic [7:0] thr_data;
    logic [3:0] spikes;
    logic       spike_valid;
    logic [1:0] rd_idx;
    logic [7:0] rd_state;

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    lif_sched #(
        .N_NEURONS(4),
        .IDX_W(2),
        .THRESH_INIT(32),
        .REFRAC_SWEEPS(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tick(tick),
        .busy(busy),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_idx(in_idx),
        .in_current(in_current),
        .thr_we(thr_we),
        .thr_data(thr_data),
        .spikes(spikes),
        .spike_valid(spike_valid),
        .rd_idx(rd_idx),
        .rd_state(rd_state)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic t, input logic v, input logic [1:0] idx,
                                 input logic [7:0] cur, input logic we, input logic [7:0] data);
        tick       = t;
        in_valid   = v;
        in_idx     = idx;
        in_current = cur;
        thr_we     = we;
        thr_data   = data;
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    task automatic checkState(input logic [1:0] idx, input logic [7:0] expected);
        rd_idx = idx;
        #1;
        checkOutput($sformatf("state%0d", idx), rd_state, expected);
    endtask

    task automatic inject(input logic [1:0] idx, input logic [7:0] cur);
        applyStimulus(1'b0, 1'b1, idx, cur, 1'b0, 8'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 8'd0);
    endtask

    // Full sweep from IDLE: tick in cycle T, UPDATE T+1..T+4, DONE T+5, back in IDLE at T+6.
    task automatic runSweep(input string tag, input logic [3:0] expSpikes, input logic thrDuring);
        applyStimulus(1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 8'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 2'd0, 8'd0, thrDuring, 8'd10);
        for (int c = 1; c <= 4; c++) begin
            checkOutput($sformatf("%s_busy_T%0d", tag, c), busy, 1'b1);
            checkOutput($sformatf("%s_sv_T%0d", tag, c), spike_valid, 1'b0);
            nextCycle();
        end
        applyStimulus(1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 8'd0);
        checkOutput({tag, "_busy_done"}, busy, 1'b1);
        checkOutput({tag, "_sv_done"}, spike_valid, 1'b1);
        checkOutput({tag, "_spikes"}, spikes, expSpikes);
        nextCycle();
        checkOutput({tag, "_busy_idle"}, busy, 1'b0);
        checkOutput({tag, "_sv_idle"}, spike_valid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        rd_idx = 2'd0;
        applyStimulus(1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 8'd0);
        repeat (2) nextCycle();

        // Reset values
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_in_ready", in_ready, 1'b1);
        checkOutput("rst_spikes", spikes, 4'b0000);
        checkOutput("rst_sv", spike_valid, 1'b0);
        for (int i = 0; i < 4; i++) checkState(2'(i), 8'd0);
        rst_n = 1'b1;
        nextCycle();

        // Empty sweep
        runSweep("empty", 4'b0000, 1'b0);
        for (int i = 0; i < 4; i++) checkState(2'(i), 8'd0);

        // Single strong injection fires neuron 2
        inject(2'd2, 8'd40);
        runSweep("n2fire", 4'b0100, 1'b0);
        checkState(2'd2, 8'd0);
        nextCycle();
        checkOutput("spikes_hold", spikes, 4'b0100);

        // Leaky integration on neuron 0: 20, 30, then 35 crosses 32
        inject(2'd0, 8'd20);
        runSweep("leak1", 4'b0000, 1'b0);
        checkState(2'd0, 8'd20);
        inject(2'd0, 8'd20);
        runSweep("leak2", 4'b0000, 1'b0);
        checkState(2'd0, 8'd30);
        inject(2'd0, 8'd20);
        runSweep("leak3", 4'b0001, 1'b0);
        checkState(2'd0, 8'd0);

        // Threshold 255 and accumulator saturation on neuron 1; threshold write during UPDATE ignored
        applyStimulus(1'b0, 1'b0, 2'd0, 8'd0, 1'b1, 8'd255);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 8'd0);
        inject(2'd1, 8'd200);
        inject(2'd1, 8'd100);
        runSweep("sat", 4'b0010, 1'b1);
        checkState(2'd1, 8'd0);
        inject(2'd3, 8'd100);
        runSweep("thrkeep", 4'b0000, 1'b0);
        checkState(2'd3, 8'd100);

        // Held injection stalls during UPDATE, lands in DONE; mid-sweep tick is dropped
        applyStimulus(1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 8'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 2'd3, 8'd10, 1'b0, 8'd0);
        checkOutput("hold_ready_T1", in_ready, 1'b0);
        nextCycle();
        checkOutput("hold_ready_T2", in_ready, 1'b0);
        tick = 1'b1;
        nextCycle();
        tick = 1'b0;
        checkOutput("hold_ready_T3", in_ready, 1'b0);
        nextCycle();
        checkOutput("hold_ready_T4", in_ready, 1'b0);
        nextCycle();
        checkOutput("hold_ready_T5", in_ready, 1'b1);
        checkOutput("hold_sv_T5", spike_valid, 1'b1);
        checkOutput("hold_spikes", spikes, 4'b0000);
        nextCycle();
        in_valid = 1'b0;
        checkOutput("hold_busy_T6", busy, 1'b0);
        nextCycle();
        checkOutput("hold_busy_T7", busy, 1'b0);
        checkState(2'd3, 8'd50);
        runSweep("heldin", 4'b0000, 1'b0);
        checkState(2'd3, 8'd35);

        // Reset in the cycle with ptr=2 aborts the sweep
        inject(2'd1, 8'd9);
        applyStimulus(1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 8'd0);
        nextCycle();
        tick = 1'b0;
        nextCycle();
        nextCycle();
        rst_n = 1'b0;
        nextCycle();
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_sv", spike_valid, 1'b0);
        checkOutput("abort_spikes", spikes, 4'b0000);
        for (int i = 0; i < 4; i++) checkState(2'(i), 8'd0);
        rst_n = 1'b1;
        nextCycle();
        checkOutput("abort_sv_after", spike_valid, 1'b0);
        checkOutput("abort_busy_after", busy, 1'b0);

        // Threshold back at 32: 32 fires, 31 does not
        inject(2'd0, 8'd32);
        inject(2'd2, 8'd31);
        runSweep("thrinit", 4'b0001, 1'b0);
        checkState(2'd0, 8'd0);
        checkState(2'd2, 8'd31);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
